unibus_arbiter: RTL and testbench



---
 rtl/unibus_pkg.sv | 63 ++++++
 rtl/unibus_sync.sv | 34 +++
 rtl/unibus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_unibus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unibus_pkg.sv
// Shared types and helpers for the Unibus bus-request arbiter.
// Optional HLTRQ/HLTGR support in the top level is enabled by `define ARB_HLTGR_EN.
package unibus_pkg;

    // Lowest BR level the arbiter serves. BR levels run from 7 down to this one.
    localparam int BR_LEVEL_LO = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACKED
    } state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_HLT,
        SEL_NPR,
        SEL_BR7,
        SEL_BR6,
        SEL_BR5,
        SEL_BR4
    } sel_e;

    // Synchronized requests, active high.
    typedef struct packed {
        logic                 hlt;
        logic                 npr;
        logic [7:BR_LEVEL_LO] br;
    } req_t;

    // A BR level may interrupt only when it is strictly above the processor priority.
    function automatic logic br_above(input int level, input logic [2:0] pri);
        return level > int'(pri);
    endfunction

    // Fixed priority: HLT, NPR, BR7, BR6, BR5, BR4.
    // BR levels also need an instruction boundary.
    function automatic sel_e pick_winner(input req_t req, input logic [2:0] cpu_pri,
                                         input logic inst_bound);
        if (req.hlt)                          return SEL_HLT;
        if (req.npr)                          return SEL_NPR;
        if (!inst_bound)                      return SEL_NONE;
        if (req.br[7] && br_above(7, cpu_pri)) return SEL_BR7;
        if (req.br[6] && br_above(6, cpu_pri)) return SEL_BR6;
        if (req.br[5] && br_above(5, cpu_pri)) return SEL_BR5;
        if (req.br[4] && br_above(4, cpu_pri)) return SEL_BR4;
        return SEL_NONE;
    endfunction

    // Reports whether the request behind a latched selection is still asserted.
    function automatic logic request_of(input sel_e sel, input req_t req);
        case (sel)
            SEL_HLT: return req.hlt;
            SEL_NPR: return req.npr;
            SEL_BR7: return req.br[7];
            SEL_BR6: return req.br[6];
            SEL_BR5: return req.br[5];
            SEL_BR4: return req.br[4];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/unibus_sync.sv
// N-bit, SYNC_STAGES-deep synchronizer for active-low bus lines.
// Reset value is all ones, so every line reads as negated.
module unibus_sync #(
    parameter int N           = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] stage_q [SYNC_STAGES];

    // Shift the raw lines through the flop chain; reset loads the negated level.
    always_ff @(posedge clk_i) begin
        // NOTE: this is a short flop chain, not a RAM, so each stage is reset; without it a
        // powered-up stage could read as an asserted request for the first few clocks.
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                // NOTE: clocked state uses <= so every stage samples its neighbour's old value.
                stage_q[s] <= '1;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/unibus_arbiter.sv
// Central Unibus bus-request arbiter. It grants NPR and BR7..BR4 one at a time,
// completes the SACK handshake, and withdraws a grant that is never acknowledged.
// Define ARB_HLTGR_EN to add HLTRQ/HLTGR. HLTRQ then ranks above NPR.
// SACK_TIMEOUT must be >= 2 and SYNC_STAGES >= 1.
module unibus_arbiter
    import unibus_pkg::*;
#(
    parameter int SACK_TIMEOUT = 500,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [2:0] cpu_pri,
    input  logic       inst_bound,
    input  logic [7:4] bus_br_in_l,
    input  logic       bus_npr_in_l,
    input  logic       bus_sack_in_l,
    input  logic       bus_init_in_l,
`ifdef ARB_HLTGR_EN
    input  logic       bus_hltrq_in_l,
    output logic       bus_hltgr_out_h,
`endif
    output logic [7:4] bus_bg_out_h,
    output logic       bus_npg_out_h,
    output logic       arb_busy,
    output logic       grant_timeout
);

    localparam int CNT_W = $clog2(SACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SACK_TIMEOUT - 1);

`ifdef ARB_HLTGR_EN
    localparam int NSYNC = 8;
`else
    localparam int NSYNC = 7;
`endif

    logic [NSYNC-1:0] raw_l;
    logic [NSYNC-1:0] sync_l;
    req_t             req;
    logic             sack;
    logic             init;
    sel_e             winner;

    state_e           state_q, state_d;
    sel_e             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // All asynchronous bus lines share one synchronizer bundle.
    // Bits [3:0] are BR4..BR7, then NPR, SACK, INIT, and HLTRQ when enabled.
`ifdef ARB_HLTGR_EN
    assign raw_l = {bus_hltrq_in_l, bus_init_in_l, bus_sack_in_l, bus_npr_in_l, bus_br_in_l};
`else
    assign raw_l = {bus_init_in_l, bus_sack_in_l, bus_npr_in_l, bus_br_in_l};
`endif

    unibus_sync #(
        .N           (NSYNC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (CLOCK),
        .rst_i (RESET),
        .d_i   (raw_l),
        .q_o   (sync_l)
    );

    assign req.br  = ~sync_l[3:0];
    assign req.npr = ~sync_l[4];
    assign sack    = ~sync_l[5];
    assign init    = ~sync_l[6];
`ifdef ARB_HLTGR_EN
    assign req.hlt = ~sync_l[7];
`else
    assign req.hlt = 1'b0;
`endif

    assign winner = pick_winner(req, cpu_pri, inst_bound);

    // State register: FSM state, latched winner, SACK-wait counter and timeout pulse.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= IDLE;
            sel_q     <= SEL_NONE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, then run the grant/SACK handshake with its timeout.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        if (init) begin
            // Bus INIT aborts any transaction quietly, even mid-grant.
            state_d = IDLE;
            sel_d   = SEL_NONE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!sack && winner != SEL_NONE) begin
                        state_d = GRANT;
                        sel_d   = winner;
                        cnt_d   = '0;
                    end
                end
                GRANT: begin
                    cnt_d = cnt_q + 1'b1;
                    // SACK wins over a simultaneous release or timeout.
                    if (sack) begin
                        state_d = ACKED;
                    end else if (!request_of(sel_q, req)) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
                ACKED: begin
                    // The next arbitration may overlap the new master's BBSY tenure.
                    if (!sack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode: drive the single grant line selected by the latched winner, from registers only.
    always_comb begin
        bus_bg_out_h  = '0;
        bus_npg_out_h = 1'b0;
`ifdef ARB_HLTGR_EN
        bus_hltgr_out_h = 1'b0;
`endif
        if (state_q == GRANT) begin
            case (sel_q)
`ifdef ARB_HLTGR_EN
                SEL_HLT: bus_hltgr_out_h = 1'b1;
`endif
                SEL_NPR: bus_npg_out_h   = 1'b1;
                SEL_BR7: bus_bg_out_h[7] = 1'b1;
                SEL_BR6: bus_bg_out_h[6] = 1'b1;
                SEL_BR5: bus_bg_out_h[5] = 1'b1;
                SEL_BR4: bus_bg_out_h[4] = 1'b1;
                default: ;
            endcase
        end
    end

    assign arb_busy      = (state_q != IDLE);
    assign grant_timeout = timeout_q;

endmodule

// File: tb/tb_unibus_arbiter.sv
// Bench for unibus_arbiter. A cycle-level behavioural model of the bus protocol is
// compared against the DUT on every falling edge. Directed scenarios also carry
// literal expectations.
module tb_unibus_arbiter;

    localparam int SACK_TIMEOUT = 500;
    localparam int SYNC_STAGES  = 2;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [2:0] cpu_pri;
    logic       inst_bound;
    logic [7:4] bus_br_in_l;
    logic       bus_npr_in_l;
    logic       bus_sack_in_l;
    logic       bus_init_in_l;
    logic [7:4] bus_bg_out_h;
    logic       bus_npg_out_h;
    logic       arb_busy;
    logic       grant_timeout;
`ifdef ARB_HLTGR_EN
    logic       bus_hltgr_out_h;
`endif

    int vectors     = 0;
    int miscompares = 0;

    unibus_arbiter #(
        .SACK_TIMEOUT (SACK_TIMEOUT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .cpu_pri       (cpu_pri),
        .inst_bound    (inst_bound),
        .bus_br_in_l   (bus_br_in_l),
        .bus_npr_in_l  (bus_npr_in_l),
        .bus_sack_in_l (bus_sack_in_l),
        .bus_init_in_l (bus_init_in_l),
`ifdef ARB_HLTGR_EN
        .bus_hltrq_in_l  (1'b1),
        .bus_hltgr_out_h (bus_hltgr_out_h),
`endif
        .bus_bg_out_h  (bus_bg_out_h),
        .bus_npg_out_h (bus_npg_out_h),
        .arb_busy      (arb_busy),
        .grant_timeout (grant_timeout)
    );

    initial forever #5 CLOCK = ~CLOCK;

    // Observed outputs, packed as {BG7..BG4, NPG, busy, timeout}.
    logic [6:0] outs;
    assign outs = {bus_bg_out_h, bus_npg_out_h, arb_busy, grant_timeout};

    function automatic logic [6:0] exp_o(input logic [7:4] bg, input logic npg,
                                         input logic busy, input logic to);
        return {bg, npg, busy, to};
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b expected %b (bg4,npg,busy,timeout)", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // holder: 0 means no master, 8 means NPR, and 4..7 means BRn.
    // age counts the clocks the grant has been up.
    typedef struct packed {
        logic [7:4] br_l;
        logic       npr_l;
        logic       sack_l;
        logic       init_l;
    } raw_t;

    raw_t pipe[$];
    int   holder      = 0;
    int   age         = 0;
    bit   acked       = 1'b0;
    bit   pulse       = 1'b0;
    bit   model_valid = 1'b0;

    function automatic int winner(input logic [7:4] br, input logic npr,
                                  input logic [2:0] pri, input logic ib);
        if (npr) return 8;
        if (ib) begin
            for (int lvl = 7; lvl >= 4; lvl--) begin
                if (br[lvl] && lvl > int'(pri)) return lvl;
            end
        end
        return 0;
    endfunction

    function automatic logic [6:0] model_out();
        logic [7:4] bg;
        bg = '0;
        for (int lvl = 4; lvl <= 7; lvl++) begin
            bg[lvl] = (holder == lvl) && !acked;
        end
        return {bg, (holder == 8) && !acked, holder != 0, pulse};
    endfunction

    // Compare the DUT with the model on each falling edge.
    // Then advance the model using the inputs the next rising edge will sample.
    initial begin
        raw_t       cur;
        raw_t       seen;
        logic [7:4] br;
        logic       npr;
        logic       sack;
        logic       init;
        int         w;
        forever begin
            @(negedge CLOCK);
            if (model_valid) check("cycle", outs, model_out());
            cur = {bus_br_in_l, bus_npr_in_l, bus_sack_in_l, bus_init_in_l};
            if (RESET) begin
                pipe.delete();
                for (int i = 0; i < SYNC_STAGES; i++) pipe.push_back('1);
                holder      = 0;
                age         = 0;
                acked       = 1'b0;
                pulse       = 1'b0;
                model_valid = 1'b1;
            end else if (model_valid) begin
                seen = pipe.pop_front();
                pipe.push_back(cur);
                br    = ~seen.br_l;
                npr   = ~seen.npr_l;
                sack  = ~seen.sack_l;
                init  = ~seen.init_l;
                pulse = 1'b0;
                if (init) begin
                    holder = 0;
                    acked  = 1'b0;
                end else if (holder == 0) begin
                    if (!sack) begin
                        w = winner(br, npr, cpu_pri, inst_bound);
                        if (w != 0) begin
                            holder = w;
                            age    = 0;
                            acked  = 1'b0;
                        end
                    end
                end else if (!acked) begin
                    age++;
                    if (sack) begin
                        acked = 1'b1;
                    end else if (!(holder == 8 ? npr : br[holder])) begin
                        holder = 0;
                    end else if (age == SACK_TIMEOUT) begin
                        holder = 0;
                        pulse  = 1'b1;
                    end
                end else if (!sack) begin
                    holder = 0;
                    acked  = 1'b0;
                end
            end
        end
    end

    // Advance n rising edges, then settle 2 time units past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLOCK);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        cpu_pri       = 3'd0;
        inst_bound    = 1'b1;
        bus_br_in_l   = 4'b1111;
        bus_npr_in_l  = 1'b1;
        bus_sack_in_l = 1'b1;
        bus_init_in_l = 1'b1;
        step(3);
        RESET = 1'b0;
        step(3);
        check("reset_state", outs, exp_o(4'b0000, 0, 0, 0));

        // NPR grant after three clocks, then the SACK handshake.
        bus_npr_in_l = 1'b0;
        step(2);
        check("npr_not_yet", outs, exp_o(4'b0000, 0, 0, 0));
        step(1);
        check("npr_grant", outs, exp_o(4'b0000, 1, 1, 0));
        bus_sack_in_l = 1'b0;
        bus_npr_in_l  = 1'b1;
        step(2);
        check("npg_before_sack", outs, exp_o(4'b0000, 1, 1, 0));
        step(1);
        check("npg_dropped_sack", outs, exp_o(4'b0000, 0, 1, 0));
        bus_sack_in_l = 1'b1;
        step(2);
        check("acked_hold", outs, exp_o(4'b0000, 0, 1, 0));
        step(1);
        check("acked_done", outs, exp_o(4'b0000, 0, 0, 0));

        // BR7 and BR5 together at priority 4: BR7 first, then BR5 after the handshake.
        cpu_pri     = 3'd4;
        bus_br_in_l = 4'b0101;
        step(3);
        check("br7_first", outs, exp_o(4'b1000, 0, 1, 0));
        bus_sack_in_l = 1'b0;
        bus_br_in_l   = 4'b1101;
        step(3);
        check("br7_acked", outs, exp_o(4'b0000, 0, 1, 0));
        bus_sack_in_l = 1'b1;
        step(3);
        check("br7_released", outs, exp_o(4'b0000, 0, 0, 0));
        step(1);
        check("br5_next", outs, exp_o(4'b0010, 0, 1, 0));
        bus_sack_in_l = 1'b0;
        bus_br_in_l   = 4'b1111;
        step(3);
        bus_sack_in_l = 1'b1;
        step(4);

        // BR7 waits for an instruction boundary; a later boundary or priority change leaves the grant alone.
        cpu_pri     = 3'd0;
        inst_bound  = 1'b0;
        bus_br_in_l = 4'b0111;
        step(10);
        check("br7_no_boundary", outs, exp_o(4'b0000, 0, 0, 0));
        inst_bound = 1'b1;
        step(1);
        check("br7_boundary", outs, exp_o(4'b1000, 0, 1, 0));
        inst_bound = 1'b0;
        cpu_pri    = 3'd7;
        step(5);
        check("br7_not_revoked", outs, exp_o(4'b1000, 0, 1, 0));
        bus_sack_in_l = 1'b0;
        bus_br_in_l   = 4'b1111;
        step(3);
        bus_sack_in_l = 1'b1;
        step(4);
        inst_bound = 1'b1;

        // BR6 is masked at priority 6; lowering the priority to 5 grants it one clock later.
        cpu_pri     = 3'd6;
        bus_br_in_l = 4'b1011;
        step(1000);
        check("br6_masked", outs, exp_o(4'b0000, 0, 0, 0));
        cpu_pri = 3'd5;
        step(1);
        check("br6_unmasked", outs, exp_o(4'b0100, 0, 1, 0));
        bus_br_in_l = 4'b1111;
        step(2);
        check("br6_still_up", outs, exp_o(4'b0100, 0, 1, 0));
        step(1);
        check("br6_passive", outs, exp_o(4'b0000, 0, 0, 0));
        cpu_pri = 3'd0;
        step(2);

        // NPR never acknowledged: the grant stays up exactly SACK_TIMEOUT clocks, then is re-granted.
        bus_npr_in_l = 1'b0;
        step(3);
        check("to_grant", outs, exp_o(4'b0000, 1, 1, 0));
        step(SACK_TIMEOUT - 1);
        check("to_last_clock", outs, exp_o(4'b0000, 1, 1, 0));
        step(1);
        check("to_pulse", outs, exp_o(4'b0000, 0, 0, 1));
        check("model_to_pulse", model_out(), exp_o(4'b0000, 0, 0, 1));
        step(1);
        check("to_regrant", outs, exp_o(4'b0000, 1, 1, 0));
        bus_npr_in_l = 1'b1;
        step(3);
        check("to_regrant_release", outs, exp_o(4'b0000, 0, 0, 0));
        step(2);

        // NPR released at clock 10 of the grant: the grant drops with no timeout pulse.
        bus_npr_in_l = 1'b0;
        step(3);
        check("rel_grant", outs, exp_o(4'b0000, 1, 1, 0));
        step(7);
        bus_npr_in_l = 1'b1;
        step(2);
        check("rel_hold", outs, exp_o(4'b0000, 1, 1, 0));
        step(1);
        check("rel_drop", outs, exp_o(4'b0000, 0, 0, 0));
        step(2);

        // INIT during a BG4 grant.
        bus_br_in_l = 4'b1110;
        step(3);
        check("bg4_grant", outs, exp_o(4'b0001, 0, 1, 0));
        bus_init_in_l = 1'b0;
        step(2);
        check("init_pending", outs, exp_o(4'b0001, 0, 1, 0));
        step(1);
        check("init_abort", outs, exp_o(4'b0000, 0, 0, 0));
        check("model_init_abort", model_out(), exp_o(4'b0000, 0, 0, 0));
        bus_br_in_l = 4'b1111;
        step(3);
        bus_init_in_l = 1'b1;
        step(3);
        check("init_released", outs, exp_o(4'b0000, 0, 0, 0));

        // RESET while in ACKED.
        bus_npr_in_l = 1'b0;
        step(3);
        check("rst_npr_grant", outs, exp_o(4'b0000, 1, 1, 0));
        bus_sack_in_l = 1'b0;
        bus_npr_in_l  = 1'b1;
        step(3);
        check("rst_acked", outs, exp_o(4'b0000, 0, 1, 0));
        RESET = 1'b1;
        step(1);
        check("rst_in_acked", outs, exp_o(4'b0000, 0, 0, 0));
        RESET         = 1'b0;
        bus_sack_in_l = 1'b1;
        step(4);
        check("rst_idle", outs, exp_o(4'b0000, 0, 0, 0));
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
